// File: rtl/ddr_sdram_pipelined_responder_if.sv
// Avalon-MM pipelined bus between the bridge master port and the scratch-RAM responder.
//  master modport: drives address/byteenable/read/write/writedata and receives
//                  waitrequest/readdata/readdatavalid/endofpacket.
//  slave modport : the mirror image, used by ddr_sdram_pipelined_responder.
interface ddr_sdram_pipelined_responder_if #(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] s_address;
  logic [BE_W-1:0]   s_byteenable;
  logic              s_read;
  logic              s_write;
  logic [DATA_W-1:0] s_writedata;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic              s_endofpacket;

  modport master (
    output s_address, s_byteenable, s_read, s_write, s_writedata,
    input  s_waitrequest, s_readdata, s_readdatavalid, s_endofpacket
  );

  modport slave (
    input  s_address, s_byteenable, s_read, s_write, s_writedata,
    output s_waitrequest, s_readdata, s_readdatavalid, s_endofpacket
  );
endinterface

// File: rtl/ddr_sdram_pipelined_responder.sv
// Avalon-MM pipelined responder fronting a single-port scratch RAM.
// Reads return exactly READ_LATENCY cycles after acceptance through a fixed shift
// pipeline; waitrequest throttles reads once MAX_PENDING are outstanding and can be
// forced by stall_inject.
//  clk, reset_n   : clock, synchronous active-low reset
//  s_bus          : Avalon-MM slave modport (request in, waitrequest/read response out)
//  stall_inject   : forces s_waitrequest high
//  pending_count  : reads accepted whose readdatavalid has not yet been issued
//  protocol_err   : sticky flag, read and write requested together
module ddr_sdram_pipelined_responder #(
  parameter int unsigned ADDR_W         = 23,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH_LOG2     = 8,
  parameter int unsigned READ_LATENCY   = 3,
  parameter int unsigned MAX_PENDING    = 4,
  parameter int unsigned EOP_BLOCK_LOG2 = 3
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  ddr_sdram_pipelined_responder_if.slave        s_bus,
  input  logic                                  stall_inject,
  output logic [3:0]                            pending_count,
  output logic                                  protocol_err
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LAT   = READ_LATENCY;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
    logic              eop;
  } rd_slot_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  rd_slot_t          r_pipe [LAT];
  logic [CNT_W-1:0]  r_pending;
  logic              r_perr;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_busy;
  logic                  w_wait;
  logic                  w_acc;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ret;
  logic                  w_eop;
  rd_slot_t              w_new;
  logic                  w_unused_addr;

  // Upper address bits only alias onto the RAM.
  assign w_idx         = s_bus.s_address[DEPTH_LOG2-1:0];
  assign w_unused_addr = ^s_bus.s_address[ADDR_W-1:DEPTH_LOG2];

  // Reads stall at the pending limit; writes only stall on injection.
  assign w_busy   = (r_pending == CNT_W'(MAX_PENDING));
  assign w_wait   = stall_inject | (reset_n & s_bus.s_read & w_busy);
  assign w_acc    = reset_n & (s_bus.s_read | s_bus.s_write) & ~w_wait;
  // Read+write together behaves as a write only.
  assign w_wr_acc = w_acc & s_bus.s_write;
  assign w_rd_acc = w_acc & s_bus.s_read & ~s_bus.s_write;
  assign w_eop    = &s_bus.s_address[EOP_BLOCK_LOG2-1:0];

  // Byte-lane RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (s_bus.s_byteenable[i]) begin
          r_mem[w_idx][i*8 +: 8] <= s_bus.s_writedata[i*8 +: 8];
        end
      end
    end
  end

  // Pipeline entry; data is zeroed for empty slots so readdata reads 0 when not valid.
  always_comb begin
    w_new = '0;
    if (w_rd_acc) begin
      w_new.vld  = 1'b1;
      w_new.data = r_mem[w_idx];
      w_new.eop  = w_eop;
    end
  end

  // Free-running return pipeline, no backpressure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_new;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // A read leaves the pending count on the edge that raises its readdatavalid.
  generate
    if (LAT == 1) begin : g_ret_direct
      assign w_ret = w_rd_acc;
    end else begin : g_ret_pipe
      assign w_ret = r_pipe[LAT-2].vld;
    end
  endgenerate

  // Outstanding-read counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else if (w_rd_acc && !w_ret) begin
      r_pending <= r_pending + CNT_W'(1);
    end else if (!w_rd_acc && w_ret) begin
      r_pending <= r_pending - CNT_W'(1);
    end
  end

  // Sticky illegal read+write flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perr <= 1'b0;
    end else if (w_acc && s_bus.s_read && s_bus.s_write) begin
      r_perr <= 1'b1;
    end
  end

  assign s_bus.s_waitrequest   = w_wait;
  assign s_bus.s_readdatavalid = r_pipe[LAT-1].vld;
  assign s_bus.s_readdata      = r_pipe[LAT-1].data;
  assign s_bus.s_endofpacket   = r_pipe[LAT-1].eop;
  assign pending_count         = r_pending;
  assign protocol_err          = r_perr;
endmodule

// File: tb/tb_ddr_sdram_pipelined_responder.sv
// Randomized bench for ddr_sdram_pipelined_responder: two instances (MAX_PENDING 4 and 2)
// driven by independent Avalon masters and checked every cycle against a return-schedule
// model indexed by clock edge.
module tb_ddr_sdram_pipelined_responder;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int LAT    = 3;
  localparam int RING   = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Request drive per instance.
  logic              rq_read  [2];
  logic              rq_write [2];
  logic [ADDR_W-1:0] rq_addr  [2];
  logic [3:0]        rq_be    [2];
  logic [DATA_W-1:0] rq_wd    [2];
  logic              rq_stall [2];

  logic [3:0] pend_a, pend_b;
  logic       perr_a, perr_b;

  ddr_sdram_pipelined_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  ddr_sdram_pipelined_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  assign bus_a.s_read       = rq_read[0];
  assign bus_a.s_write      = rq_write[0];
  assign bus_a.s_address    = rq_addr[0];
  assign bus_a.s_byteenable = rq_be[0];
  assign bus_a.s_writedata  = rq_wd[0];
  assign bus_b.s_read       = rq_read[1];
  assign bus_b.s_write      = rq_write[1];
  assign bus_b.s_address    = rq_addr[1];
  assign bus_b.s_byteenable = rq_be[1];
  assign bus_b.s_writedata  = rq_wd[1];

  ddr_sdram_pipelined_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(8), .READ_LATENCY(LAT),
    .MAX_PENDING(4), .EOP_BLOCK_LOG2(3)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .s_bus(bus_a.slave), .stall_inject(rq_stall[0]),
    .pending_count(pend_a), .protocol_err(perr_a)
  );

  ddr_sdram_pipelined_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(8), .READ_LATENCY(LAT),
    .MAX_PENDING(2), .EOP_BLOCK_LOG2(3)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .s_bus(bus_b.slave), .stall_inject(rq_stall[1]),
    .pending_count(pend_b), .protocol_err(perr_b)
  );

  // Reference model: RAM image plus expected return per clock edge.
  logic [31:0] mram  [2][DEPTH];
  logic        exp_v [2][RING];
  logic [31:0] exp_d [2][RING];
  logic        exp_e [2][RING];
  int          pend_m [2];
  logic        perr_m [2];
  bit          acc    [2];
  int          k = 0;
  bit          armed = 0;

  // Stimulus knobs.
  int p_read, p_write, p_stall, p_both, p_rst;
  bit seq, full_be;
  int next_addr [2];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got 0x%08h expected 0x%08h", tag, k, obs, exp);
    end
  endtask

  function automatic int max_pend(input int id);
    return (id == 0) ? 4 : 2;
  endfunction

  // Check outputs after edge k, then apply the upcoming edge k+1 to the model.
  task automatic step(input int id);
    int          s, t, idx, cnt;
    logic        w_exp;
    logic        ow, orv, oeop, operr;
    logic [31:0] ord;
    logic [3:0]  op;
    if (id == 0) begin
      ow = bus_a.s_waitrequest; orv = bus_a.s_readdatavalid; ord = bus_a.s_readdata;
      oeop = bus_a.s_endofpacket; op = pend_a; operr = perr_a;
    end else begin
      ow = bus_b.s_waitrequest; orv = bus_b.s_readdatavalid; ord = bus_b.s_readdata;
      oeop = bus_b.s_endofpacket; op = pend_b; operr = perr_b;
    end
    s = k % RING;
    w_exp = rq_stall[id] | (reset_n & rq_read[id] & (pend_m[id] == max_pend(id)));
    if (armed) begin
      chk($sformatf("waitrequest%0d", id), 32'(ow), 32'(w_exp));
      chk($sformatf("readdatavalid%0d", id), 32'(orv), 32'(exp_v[id][s]));
      chk($sformatf("readdata%0d", id), ord, exp_v[id][s] ? exp_d[id][s] : 32'h0);
      chk($sformatf("endofpacket%0d", id), 32'(oeop), exp_v[id][s] ? 32'(exp_e[id][s]) : 32'h0);
      chk($sformatf("pending%0d", id), 32'(op), 32'(pend_m[id]));
      chk($sformatf("protocol_err%0d", id), 32'(operr), 32'(perr_m[id]));
    end
    exp_v[id][s] = 1'b0;
    if (!reset_n) begin
      for (int j = 0; j < RING; j++) exp_v[id][j] = 1'b0;
      pend_m[id] = 0;
      perr_m[id] = 1'b0;
      acc[id]    = 1'b0;
    end else begin
      acc[id] = (rq_read[id] | rq_write[id]) & ~w_exp;
      idx = int'(rq_addr[id][7:0]);
      if (acc[id] && rq_write[id]) begin
        for (int b = 0; b < 4; b++)
          if (rq_be[id][b]) mram[id][idx][8*b +: 8] = rq_wd[id][8*b +: 8];
        if (rq_read[id]) perr_m[id] = 1'b1;
      end else if (acc[id] && rq_read[id]) begin
        t = (k + LAT) % RING;
        exp_v[id][t] = 1'b1;
        exp_d[id][t] = mram[id][idx];
        exp_e[id][t] = &rq_addr[id][2:0];
      end
      // Pending after edge k+1: accepted reads whose return edge is still ahead.
      cnt = 0;
      for (int e = k + 2; e <= k + LAT; e++) if (exp_v[id][e % RING]) cnt++;
      pend_m[id] = cnt;
    end
  endtask

  always @(negedge clk) begin
    step(0);
    step(1);
    k++;
  end

  // Avalon master: hold a request until the model says it was accepted.
  task automatic drive(input int id);
    bit r, w;
    rq_stall[id] = ($urandom_range(99) < p_stall);
    if ((rq_read[id] || rq_write[id]) && !acc[id]) return;
    r = ($urandom_range(99) < p_read);
    w = ($urandom_range(99) < p_write);
    if (r && w && !($urandom_range(99) < p_both)) r = 1'b0;
    rq_read[id]  = r;
    rq_write[id] = w;
    if (seq) begin
      rq_addr[id] = ADDR_W'(next_addr[id]);
      if (r || w) next_addr[id]++;
    end else begin
      rq_addr[id] = ADDR_W'($urandom());
    end
    rq_be[id] = full_be ? 4'hF : 4'($urandom());
    rq_wd[id] = $urandom();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      reset_n = ($urandom_range(999) < p_rst) ? 1'b0 : 1'b1;
      drive(0);
      drive(1);
    end
  endtask

  task automatic set_mode(input int r, input int w, input int st, input int bo, input int rs,
                          input bit sq, input bit fb);
    p_read = r; p_write = w; p_stall = st; p_both = bo; p_rst = rs; seq = sq; full_be = fb;
    next_addr[0] = 0;
    next_addr[1] = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    set_mode(0, 0, 0, 0, 0, 1'b0, 1'b1);
    for (int id = 0; id < 2; id++) begin
      rq_read[id] = 1'b1; rq_write[id] = 1'b0; rq_addr[id] = ADDR_W'(5);
      rq_be[id] = 4'hF; rq_wd[id] = '0; rq_stall[id] = 1'b0;
      pend_m[id] = 0; perr_m[id] = 1'b0;
      for (int j = 0; j < RING; j++) exp_v[id][j] = 1'b0;
    end
    // Reset held for three edges with a read request pending.
    @(posedge clk);
    armed = 1;
    repeat (2) @(posedge clk);
    #1;
    rq_read[0] = 1'b0;
    rq_read[1] = 1'b0;
    reset_n = 1'b1;
    // Fill every RAM word with full-width writes.
    set_mode(0, 100, 0, 0, 0, 1'b1, 1'b1);
    run(300);
    // Sequential read burst from word 0.
    set_mode(100, 0, 0, 0, 0, 1'b1, 1'b1);
    run(40);
    // Mixed traffic: partial writes, aliasing, stalls, read+write, random resets.
    set_mode(50, 40, 15, 10, 8, 1'b0, 1'b0);
    run(1500);
    // Read-heavy traffic to drive the pending limit.
    set_mode(85, 15, 5, 0, 0, 1'b0, 1'b0);
    run(500);
    // Drain.
    set_mode(0, 0, 0, 0, 0, 1'b0, 1'b1);
    run(10);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
